icache_refill_ctrl: RTL
=======================

ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16, byte-address width of pc/memory address.
REQ-002 Parameter WORD_W, default 16, instruction/memory beat width; line = 4 words = 4*WORD_W bits.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 fetch_en  in  1  pipeline fetch valid this cycle.
REQ-006 pc  in  ADDR_W  fetch byte address.
REQ-007 hit  in  1  cache hit for pc (combinational from cache).
REQ-008 flush  in  1  abort any in-progress refill.
REQ-009 mem_req  out  1  memory read request, level-held.
REQ-010 mem_addr  out  ADDR_W  memory beat byte address.
REQ-011 mem_ready  in  1  beat accepted; mem_data valid when mem_req & mem_ready.
REQ-012 mem_data  in  WORD_W  returned instruction word.
REQ-013 fill_en  out  1  one-cycle cache line write strobe.
REQ-014 fill_addr  out  ADDR_W  line base address for write.
REQ-015 fill_data  out  4*WORD_W  line; word k at bits [k*WORD_W+WORD_W-1 : k*WORD_W].
REQ-016 stall  out  1  freeze pipeline fetch.
REQ-017 miss_count  out  16  refill counter (only with REFILL_PERF_CNT_EN).

Function
REQ-018 FSM states SHALL be IDLE, REQ, FILL, SETTLE.
REQ-019 IDLE: fetch_en & !hit & !flush SHALL latch base = pc with low log2(4*WORD_W/8) bits cleared, clear beat counter, go REQ.
REQ-020 REQ: mem_req=1, mem_addr = base + beat*(WORD_W/8); on mem_ready capture mem_data into word[beat], beat++.
REQ-021 REQ: accepted beat 3 SHALL transition to FILL; beats without mem_ready SHALL hold mem_addr and beat unchanged.
REQ-022 FILL: fill_en=1 for exactly one cycle, fill_addr=base, fill_data=assembled line; next state SETTLE.
REQ-023 SETTLE: one cycle for cache tag/valid update, fill_en=0, mem_req=0; next IDLE.
REQ-024 stall SHALL equal (state != IDLE) | (fetch_en & !hit) combinationally.
REQ-025 pc/hit changes while not IDLE SHALL be ignored (base latched).
REQ-026 flush in REQ SHALL go IDLE next cycle, drop any beat accepted that cycle, never assert fill_en; flush in FILL SHALL still complete the fill (line is consistent); flush in IDLE suppresses miss detection.
REQ-027 With mem_ready always high, miss-to-fill_en latency SHALL be 5 cycles (IDLE detect + 4 beats), stall released earliest 7 cycles after detect.
REQ-028 Outputs mem_req, fill_en SHALL be 0 outside REQ/FILL respectively; fill_data SHALL hold last assembled line otherwise.

Reset
REQ-029 rst SHALL force IDLE, beat=0, base=0, line buffer=0, mem_req=0, fill_en=0, miss_count=0.
REQ-030 rst mid-refill SHALL abandon it with no fill_en pulse; stall then follows REQ-024 from IDLE.

Configuration
REQ-031 Macro REFILL_PERF_CNT_EN defined: miss_count increments once per FILL entry, saturates at 16'hFFFF, aborted refills not counted.
REQ-032 Macro undefined: miss_count port SHALL be present and tied to 0, no counter logic.

Verification
REQ-033 rst, fetch_en=1, pc=16'h000A, hit=0, mem_ready=1, mem_data 0004..0007 -> mem_addr 0008,000A,000C,000E; fill_en cycle 5 with fill_addr 0008, fill_data 64'h0007000600050004.
REQ-034 Same miss, mem_ready low 3 cycles before beat 2 -> mem_addr held at 000C, fill_en delayed exactly 3 cycles, data unchanged.
REQ-035 fetch_en=1, hit=1, pc stepping 0,2,4,6 -> stall=0, mem_req never asserted.
REQ-036 flush after beat 1 accepted -> IDLE next cycle, no fill_en, miss_count unchanged.
REQ-037 rst asserted during REQ beat 2 -> next cycle mem_req=0, fill_en never pulses, all outputs at reset values.
REQ-038 With REFILL_PERF_CNT_EN, three completed misses and one flushed -> miss_count=3; without macro -> miss_count=0.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss refill controller: fetches a 4-word line beat by beat and writes it to the cache.
// Optional macro REFILL_PERF_CNT_EN adds a saturating completed-refill counter on miss_count.
module icache_refill_ctrl #(
    parameter int ADDR_W = 16,
    parameter int WORD_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic [ADDR_W-1:0]     pc,
    input  logic                  hit,
    input  logic                  flush,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_ready,
    input  logic [WORD_W-1:0]     mem_data,
    output logic                  fill_en,
    output logic [ADDR_W-1:0]     fill_addr,
    output logic [4*WORD_W-1:0]   fill_data,
    output logic                  stall,
    output logic [15:0]           miss_count
);

    localparam int WORD_BYTES = WORD_W / 8;
    localparam int LINE_BYTES = 4 * WORD_BYTES;
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(LINE_BYTES - 1);

    typedef enum logic [1:0] {IDLE, REQ, FILL, SETTLE} state_t;

    state_t              state_reg, state_next;
    logic [1:0]          beat_reg, beat_next;
    logic [ADDR_W-1:0]   base_reg, base_next;
    logic [4*WORD_W-1:0] line_reg;
    logic [4*WORD_W-1:0] captured;
    logic                miss_detect;
    logic                beat_accept;
    logic                last_beat;

    assign miss_detect = fetch_en & ~hit & ~flush;
    // A flush in REQ wins over mem_ready, so the beat returned that cycle is dropped.
    assign beat_accept = (state_reg == REQ) & mem_ready & ~flush;
    assign last_beat   = beat_accept & (beat_reg == 2'd3);

    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        base_next  = base_reg;
        case (state_reg)
            IDLE: begin
                if (miss_detect) begin
                    base_next  = pc & ~OFFSET_MASK;
                    beat_next  = 2'd0;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (mem_ready) begin
                    beat_next = beat_reg + 2'd1;
                    if (beat_reg == 2'd3) begin
                        state_next = FILL;
                    end
                end
            end
            FILL:    state_next = SETTLE;
            SETTLE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            beat_reg  <= 2'd0;
            base_reg  <= '0;
            line_reg  <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            base_reg  <= base_next;
            // The line is published only once complete, so fill_data never shows a partial refill.
            if (last_beat) begin
                line_reg <= captured;
            end
        end
    end

    // Words 0..2 are buffered; word 3 is taken straight from the bus on the final beat.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : gen_word
            logic [WORD_W-1:0] word_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    word_reg <= '0;
                end else if (beat_accept && (beat_reg == 2'(gi))) begin
                    word_reg <= mem_data;
                end
            end
            assign captured[gi*WORD_W +: WORD_W] = word_reg;
        end
    endgenerate
    assign captured[3*WORD_W +: WORD_W] = mem_data;

    assign mem_req   = (state_reg == REQ);
    assign mem_addr  = base_reg + ADDR_W'(beat_reg) * ADDR_W'(WORD_BYTES);
    assign fill_en   = (state_reg == FILL);
    assign fill_addr = base_reg;
    assign fill_data = line_reg;
    assign stall     = (state_reg != IDLE) | (fetch_en & ~hit);

`ifdef REFILL_PERF_CNT_EN
    logic [15:0] miss_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            miss_count_reg <= 16'h0000;
        end else if (last_beat && (miss_count_reg != 16'hFFFF)) begin
            miss_count_reg <= miss_count_reg + 16'h0001;
        end
    end

    assign miss_count = miss_count_reg;
`else
    assign miss_count = 16'h0000;
`endif

endmodule
